// File: rtl/smart_row_drain_pkg.sv
// smart_row_drain_pkg: shared FSM encoding, width helper and default word size for the row drain
package smart_row_drain_pkg;

    localparam int DEFAULT_WORD_SIZE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } drain_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/smart_row_drain_fifo.sv
// smart_row_drain_fifo: show-ahead synchronous FIFO with occupancy count and async active-low reset
module smart_row_drain_fifo
    import smart_row_drain_pkg::*;
#(
    parameter int WORD_SIZE  = DEFAULT_WORD_SIZE,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push,
    input  logic                               pop,
    input  logic [WORD_SIZE-1:0]               wdata,
    output logic [WORD_SIZE-1:0]               rdata,
    output logic [clog2(FIFO_DEPTH+1)-1:0]     count,
    output logic                               full,
    output logic                               empty
);

    localparam int CW = clog2(FIFO_DEPTH + 1);
    localparam int PW = clog2(FIFO_DEPTH) < 1 ? 1 : clog2(FIFO_DEPTH);

    logic [WORD_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 push_ok, pop_ok;

    assign full    = cnt_q == CW'(FIFO_DEPTH);
    assign empty   = cnt_q == '0;
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_q];
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    // Next pointers wrap at FIFO_DEPTH so non-power-of-two depths work
    always_comb begin
        wr_d  = push_ok ? (wr_q == PW'(FIFO_DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d  = pop_ok ? (rd_q == PW'(FIFO_DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
        cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Storage and pointers; storage cleared on reset so the head reads zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) mem_q[wr_q] <= wdata;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/smart_row_drain.sv
// smart_row_drain: walks a PE row's right_out selects, captures bus words into a FIFO, streams them out
module smart_row_drain
    import smart_row_drain_pkg::*;
#(
    parameter int WORD_SIZE  = DEFAULT_WORD_SIZE,
    parameter int NUM_COLS   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           drain_start_in,
    input  logic [WORD_SIZE-1:0]           horizontal_smart_bus_in,
    output logic [NUM_COLS-1:0]            select_right_out_smart_out,
    output logic [WORD_SIZE-1:0]           data_out,
    output logic                           data_valid_out,
    input  logic                           data_ready_in,
    output logic [clog2(FIFO_DEPTH+1)-1:0] fifo_count_out,
    output logic                           drain_busy_out,
    output logic                           drain_done_out
);

    localparam int CW = clog2(FIFO_DEPTH + 1);
    localparam int LW = clog2(NUM_COLS) < 1 ? 1 : clog2(NUM_COLS);

    drain_state_e  state_q, state_d;
    logic [LW-1:0] col_q, col_d;
    logic          push, pop, full, empty, last_col;

    assign pop      = data_valid_out && data_ready_in;
    assign push     = (state_q == DRAIN) && (!full || pop);
    assign last_col = col_q == LW'(NUM_COLS - 1);

    assign data_valid_out             = !empty;
    assign select_right_out_smart_out = (state_q == DRAIN) ? NUM_COLS'(1) << col_q : '0;
    assign drain_busy_out             = (state_q == DRAIN) || (state_q == FLUSH);
    assign drain_done_out             = state_q == DONE;

    smart_row_drain_fifo #(
        .WORD_SIZE (WORD_SIZE),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .wdata(horizontal_smart_bus_in),
        .rdata(data_out),
        .count(fifo_count_out),
        .full (full),
        .empty(empty)
    );

    // Column walk advances only on a capture; flush exits once the FIFO empties this cycle
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        case (state_q)
            IDLE:  if (drain_start_in) begin
                       state_d = DRAIN;
                       col_d   = '0;
                   end
            DRAIN: if (push) begin
                       col_d   = last_col ? '0 : col_q + 1'b1;
                       state_d = last_col ? FLUSH : DRAIN;
                   end
            FLUSH: if (fifo_count_out == '0 || (fifo_count_out == CW'(1) && pop)) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state and column index registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
        end
    end

endmodule

// File: doc/smart_row_drain.md
Name: smart_row_drain

Overview:
- Row-end output collector for one row of smart_mac PEs.
- After a compute pass, it walks the row's select_right_out_smart lines one column at a time. Each PE's right_out travels down the horizontal smart bus to the row end, where this block captures it.
- Captured words are buffered in a local FIFO and presented downstream on a valid/ready interface, stalling the column walk whenever the FIFO is full.

Parameters:
- WORD_SIZE, 16, width of bus and data words.
- NUM_COLS, 4, number of smart_mac PEs in the row.
- FIFO_DEPTH, 8, output buffer entries; any integer >= 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- drain_start_in  in  1  one-cycle request to drain the row; honoured only in IDLE.
- horizontal_smart_bus_in  in  WORD_SIZE  horizontal_smart_bus_out of the last PE in the row.
- select_right_out_smart_out  out  NUM_COLS  one-hot; bit c drives select_right_out_smart of column c (column 0 is leftmost).
- data_out  out  WORD_SIZE  FIFO head word (show-ahead).
- data_valid_out  out  1  FIFO non-empty.
- data_ready_in  in  1  downstream accepts data_out this cycle.
- fifo_count_out  out  clog2(FIFO_DEPTH+1)  current occupancy.
- drain_busy_out  out  1  high in DRAIN and FLUSH.
- drain_done_out  out  1  one-cycle pulse when a drain completes.

Behaviour:
- Reset (rst=0, asynchronous) drives: state=IDLE, col=0, FIFO pointers and count=0, and every output to 0, including select_right_out_smart_out, data_valid_out and drain_done_out. data_out=0 because FIFO storage is cleared on reset.
- Reset mid-drain aborts the drain immediately. No done pulse is issued and partial FIFO contents are lost.
- FSM states: IDLE, DRAIN, FLUSH, DONE.
- IDLE:
  - select all zero, so the bus passes through.
  - drain_start_in=1 -> DRAIN, col=0.
- DRAIN:
  - select_right_out_smart_out = 1<<col, held stable until that column is captured.
  - The bus is combinational through the row, so the selected PE's right_out is valid at the row end in the same cycle.
  - push = (count<FIFO_DEPTH) || pop. On a push edge, bus word -> FIFO and col increments.
  - If push=0, col and select hold (stall); no word is lost or duplicated.
  - Push of col=NUM_COLS-1 -> FLUSH, and select returns to 0 on the next cycle.
- FLUSH:
  - Waits for count==0, taking the pop in the same cycle into account.
  - Then -> DONE.
- DONE:
  - drain_done_out=1 for exactly one cycle, then -> IDLE.
  - drain_start_in is ignored in DONE and accepted again from IDLE on the following cycle.
- drain_start_in in DRAIN, FLUSH or DONE is ignored and not queued.
- FIFO:
  - pop = data_valid_out && data_ready_in.
  - Simultaneous push and pop leaves count unchanged; this is legal when full (a pop frees the slot) and when the FIFO holds one entry.
  - Pointers wrap modulo FIFO_DEPTH.
  - data_out = mem[rd_ptr]; valid whenever count!=0.
  - data_valid_out is never high while count==0. A push into an empty FIFO becomes visible the cycle after the push edge (no fall-through).
- Throughput: one column per cycle when not backpressured. Minimum drain-to-done latency is NUM_COLS + 2 cycles with data_ready_in tied high.
- Output order is strictly column 0 .. NUM_COLS-1.
- No arithmetic beyond pointer/count increments. Count width is clog2(FIFO_DEPTH+1); col width is clog2(NUM_COLS), minimum 1.

Decomposition:
- Shared include (smart_array_defs.vh):
  - FSM state encodings (2-bit localparams: IDLE, DRAIN, FLUSH, DONE).
  - clog2 constant function.
  - Default WORD_SIZE.
- One sub-module: sync_fifo (parameters WORD_SIZE, FIFO_DEPTH).
  - Ports: push, pop, wdata, rdata, count, full, empty.
  - Same clk and active-low async rst.
  - Reusable for the column-side drain.

Test Plan:
- Reset mid-drain:
  - Stimulus: start a drain, then assert rst=0 after 2 captures.
  - Required: all outputs 0 asynchronously. After release, state IDLE, count 0, no drain_done_out pulse.
- Basic drain:
  - Stimulus: NUM_COLS=4, ready=1, PE outputs 0x0011, 0x0022, 0x0033, 0x0044 modelled on the bus; pulse start.
  - Required: select sequence 0001, 0010, 0100, 1000; data_out 0x0011..0x0044 in order; done 6 cycles after start.
- Backpressure:
  - Stimulus: FIFO_DEPTH=2, ready=0 during drain.
  - Required: after 2 captures, select holds at 0100 and count=2. Raising ready for one cycle pops 0x0011 and captures 0x0033 on the same edge, with count staying 2.
- Start while busy:
  - Stimulus: pulse drain_start_in during DRAIN and again during DONE.
  - Required: exactly 4 words output and a single done pulse.
- FIFO wrap:
  - Stimulus: FIFO_DEPTH=3; three back-to-back drains with ready toggling 1/0 each cycle.
  - Required: all 12 words in order, no loss or duplication, count never exceeds 3.
